dispatch_ctrl_param: RTL and testbench

Parametrised dispatch control stage for the Tomasulo-style RISC-V core. It sits between the fetch queue or decoder and N execution reservation stations. It owns the tag free list and the register status table, and routes each instruction to one of N_UNITS queues. It also runs a branch-stall state machine with a one-cycle flush pulse on a taken branch. Unit count, tag count and architectural register count are generic.

---
 rtl/dispatch_ctrl_param_if.sv | 44 ++++
 rtl/dispatch_ctrl_param.sv | 166 ++++++++++++++++
 tb/tb_dispatch_ctrl_param.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dispatch_ctrl_param_if.sv
// Handshake bundle between the decode/fetch side, the CDB and the dispatch control stage.
// The master drives instruction, queue-status and CDB inputs; the slave returns dispatch decisions.
interface dispatch_ctrl_param_if #(
    parameter int N_UNITS = 4,
    parameter int TAG_W   = 6,
    parameter int ARCH_W  = 5
);
    logic               i_fetch_valid;
    logic [N_UNITS-1:0] i_unit_sel;
    logic               i_rd_wr;
    logic [ARCH_W-1:0]  i_rd_addr;
    logic [ARCH_W-1:0]  i_rs1_addr;
    logic [ARCH_W-1:0]  i_rs2_addr;
    logic               i_is_branch;
    logic [N_UNITS-1:0] i_queue_full;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic               cdb_branch;
    logic               cdb_branch_taken;
    logic [N_UNITS-1:0] o_dispatch_en;
    logic               o_fetch_rd_en;
    logic [TAG_W-1:0]   o_rd_tag;
    logic [TAG_W-1:0]   o_rs1_tag;
    logic [TAG_W-1:0]   o_rs2_tag;
    logic               o_rs1_pend;
    logic               o_rs2_pend;
    logic               o_flush;
    logic               o_stall;
    logic               o_tags_empty;

    modport master (
        output i_fetch_valid, i_unit_sel, i_rd_wr, i_rd_addr, i_rs1_addr, i_rs2_addr,
               i_is_branch, i_queue_full, cdb_valid, cdb_tag, cdb_branch, cdb_branch_taken,
        input  o_dispatch_en, o_fetch_rd_en, o_rd_tag, o_rs1_tag, o_rs2_tag,
               o_rs1_pend, o_rs2_pend, o_flush, o_stall, o_tags_empty
    );

    modport slave (
        input  i_fetch_valid, i_unit_sel, i_rd_wr, i_rd_addr, i_rs1_addr, i_rs2_addr,
               i_is_branch, i_queue_full, cdb_valid, cdb_tag, cdb_branch, cdb_branch_taken,
        output o_dispatch_en, o_fetch_rd_en, o_rd_tag, o_rs1_tag, o_rs2_tag,
               o_rs1_pend, o_rs2_pend, o_flush, o_stall, o_tags_empty
    );
endinterface

// File: rtl/dispatch_ctrl_param.sv
// Dispatch control: tag free list, register status table, queue routing and
// a branch-stall FSM that emits a one-cycle flush on a taken branch.
module dispatch_ctrl_param_chk (
    input logic i_clk,
    input logic i_rst,
    input logic push_req,
    input logic list_full
);
    a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst) !(push_req && list_full));
endmodule

module dispatch_ctrl_param #(
    parameter int N_UNITS = 4,
    parameter int TAG_W   = 6,
    parameter int ARCH_W  = 5
) (
    input logic                  i_clk,
    input logic                  i_rst,
    dispatch_ctrl_param_if.slave bus
);
    localparam int NUM_TAGS = 2 ** TAG_W;
    localparam int NUM_ARCH = 2 ** ARCH_W;
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(NUM_TAGS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TAG_W-1:0]  fl_mem_r [NUM_TAGS];
    logic [TAG_W-1:0]  head_r;
    logic [TAG_W-1:0]  tail_r;
    logic [TAG_W:0]    count_r;
    logic              rst_valid_r [NUM_ARCH];
    logic [TAG_W-1:0]  rst_tag_r   [NUM_ARCH];

    logic              need_tag_s;
    logic              tags_empty_s;
    logic              list_full_s;
    logic              stall_s;
    logic              go_s;
    logic              pop_s;
    logic              push_s;
    logic [TAG_W-1:0]  head_tag_s;

    // A source is pending when its producer is outstanding and not being broadcast this cycle.
    function automatic logic src_pending(input logic ent_valid, input logic [TAG_W-1:0] ent_tag,
                                         input logic bc_valid, input logic [TAG_W-1:0] bc_tag,
                                         input logic is_x0);
        return ent_valid & ~(bc_valid & (bc_tag == ent_tag)) & ~is_x0;
    endfunction

    // Dispatch decision, free-list handshakes and source lookup.
    always_comb begin
        need_tag_s   = bus.i_rd_wr & (bus.i_rd_addr != {ARCH_W{1'b0}});
        tags_empty_s = (count_r == {(TAG_W + 1){1'b0}});
        list_full_s  = (count_r == FULL_CNT);
        head_tag_s   = fl_mem_r[head_r];
        stall_s      = (state_r != ST_IDLE) | (|(bus.i_unit_sel & bus.i_queue_full))
                     | (need_tag_s & tags_empty_s);
        go_s         = bus.i_fetch_valid & ~stall_s;
        pop_s        = go_s & need_tag_s;
        push_s       = bus.cdb_valid & ~list_full_s;

        bus.o_dispatch_en = go_s ? bus.i_unit_sel : {N_UNITS{1'b0}};
        bus.o_fetch_rd_en = go_s;
        bus.o_stall       = stall_s;
        bus.o_tags_empty  = tags_empty_s;
        bus.o_flush       = (state_r == ST_FLUSH);
        bus.o_rd_tag      = head_tag_s;
        bus.o_rs1_tag     = rst_tag_r[bus.i_rs1_addr];
        bus.o_rs2_tag     = rst_tag_r[bus.i_rs2_addr];
        bus.o_rs1_pend    = src_pending(rst_valid_r[bus.i_rs1_addr], rst_tag_r[bus.i_rs1_addr],
                                        bus.cdb_valid, bus.cdb_tag,
                                        bus.i_rs1_addr == {ARCH_W{1'b0}});
        bus.o_rs2_pend    = src_pending(rst_valid_r[bus.i_rs2_addr], rst_tag_r[bus.i_rs2_addr],
                                        bus.cdb_valid, bus.cdb_tag,
                                        bus.i_rs2_addr == {ARCH_W{1'b0}});
    end

    // Branch FSM next-state: only BR_WAIT reacts to a CDB branch resolution.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s && bus.i_is_branch) begin
                    state_nxt_s = ST_BR_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BR_WAIT: begin
                if (bus.cdb_branch) begin
                    state_nxt_s = bus.cdb_branch_taken ? ST_FLUSH : ST_IDLE;
                end else begin
                    state_nxt_s = ST_BR_WAIT;
                end
            end
            ST_FLUSH: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Branch FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Circular free list; a push into a full list is dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                fl_mem_r[i] <= TAG_W'(i);
            end
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= FULL_CNT;
        end else begin
            if (push_s) begin
                fl_mem_r[tail_r] <= bus.cdb_tag;
                tail_r           <= tail_r + TAG_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + TAG_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + (TAG_W + 1)'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - (TAG_W + 1)'(1);
            end
        end
    end

    // Register status table; a dispatch write to an entry overrides a same-cycle CDB clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rst_valid_r[i] <= 1'b0;
                rst_tag_r[i]   <= {TAG_W{1'b0}};
            end
        end else begin
            for (int i = 1; i < NUM_ARCH; i++) begin
                if (pop_s && (bus.i_rd_addr == ARCH_W'(i))) begin
                    rst_valid_r[i] <= 1'b1;
                    rst_tag_r[i]   <= head_tag_s;
                end else if (bus.cdb_valid && rst_valid_r[i] && (rst_tag_r[i] == bus.cdb_tag)) begin
                    rst_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    dispatch_ctrl_param_chk u_chk (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push_req  (bus.cdb_valid),
        .list_full (list_full_s)
    );
endmodule

// File: tb/tb_dispatch_ctrl_param.sv
// Scoreboard bench for dispatch_ctrl_param: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dispatch_ctrl_param;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    typedef struct {
        string      name;
        logic [3:0] en;
        logic       rd_en;
        logic       stall;
        logic       flush;
        logic       empty;
        logic [5:0] rd_tag;
        logic [5:0] rs1_tag;
        logic       rs1_pend;
        logic [5:0] rs2_tag;
        logic       rs2_pend;
    } exp_t;

    exp_t sb[$];

    dispatch_ctrl_param_if #(.N_UNITS(4), .TAG_W(6), .ARCH_W(5)) bus ();

    dispatch_ctrl_param #(.N_UNITS(4), .TAG_W(6), .ARCH_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, exp);
        end
    endtask

    // Monitor: one expectation per cycle in which the driver queued one.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "dispatch_en", 32'(bus.o_dispatch_en), 32'(e.en));
            cmp(e.name, "fetch_rd_en", 32'(bus.o_fetch_rd_en), 32'(e.rd_en));
            cmp(e.name, "stall",       32'(bus.o_stall),       32'(e.stall));
            cmp(e.name, "flush",       32'(bus.o_flush),       32'(e.flush));
            cmp(e.name, "tags_empty",  32'(bus.o_tags_empty),  32'(e.empty));
            cmp(e.name, "rd_tag",      32'(bus.o_rd_tag),      32'(e.rd_tag));
            cmp(e.name, "rs1_tag",     32'(bus.o_rs1_tag),     32'(e.rs1_tag));
            cmp(e.name, "rs1_pend",    32'(bus.o_rs1_pend),    32'(e.rs1_pend));
            cmp(e.name, "rs2_tag",     32'(bus.o_rs2_tag),     32'(e.rs2_tag));
            cmp(e.name, "rs2_pend",    32'(bus.o_rs2_pend),    32'(e.rs2_pend));
        end
    end

    task automatic clr();
        bus.i_fetch_valid    = 1'b0;
        bus.i_unit_sel       = 4'b0000;
        bus.i_rd_wr          = 1'b0;
        bus.i_rd_addr        = 5'd0;
        bus.i_rs1_addr       = 5'd0;
        bus.i_rs2_addr       = 5'd0;
        bus.i_is_branch      = 1'b0;
        bus.i_queue_full     = 4'b0000;
        bus.cdb_valid        = 1'b0;
        bus.cdb_tag          = 6'd0;
        bus.cdb_branch       = 1'b0;
        bus.cdb_branch_taken = 1'b0;
    endtask

    task automatic disp(input logic [3:0] sel, input logic rd_wr, input logic [4:0] rd);
        clr();
        bus.i_fetch_valid = 1'b1;
        bus.i_unit_sel    = sel;
        bus.i_rd_wr       = rd_wr;
        bus.i_rd_addr     = rd;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] en, input logic rd_en,
                              input logic stall, input logic flush, input logic empty,
                              input logic [5:0] rd_tag, input logic [5:0] rs1_tag,
                              input logic rs1_pend, input logic [5:0] rs2_tag, input logic rs2_pend);
        exp_t e;
        e.name = nm; e.en = en; e.rd_en = rd_en; e.stall = stall; e.flush = flush;
        e.empty = empty; e.rd_tag = rd_tag; e.rs1_tag = rs1_tag; e.rs1_pend = rs1_pend;
        e.rs2_tag = rs2_tag; e.rs2_pend = rs2_pend;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        clr();
        step();

        // Reset state, then release
        expect_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        rst = 1'b0;

        // Three rd writes on unit 0 take tags 0,1,2
        disp(4'b0001, 1'b1, 5'd5);
        expect_out("disp_x5", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b1, 5'd6);
        expect_out("disp_x6", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b1, 5'd7);
        expect_out("disp_x7", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2, 6'd0, 1'b0, 6'd0, 1'b0);
        step();

        // Dependent reads, CDB bypass, then cleared entry
        disp(4'b0001, 1'b0, 5'd0);
        bus.i_rs1_addr = 5'd5; bus.i_rs2_addr = 5'd6;
        expect_out("dep_read", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 1'b1, 6'd1, 1'b1);
        step();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd0;
        expect_out("dep_bypass", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 1'b0, 6'd1, 1'b1);
        step();
        clr();
        bus.i_rs1_addr = 5'd5;
        expect_out("dep_cleared", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 1'b0, 6'd0, 1'b0);
        step();

        // Queue full blocks dispatch and does not pop a tag
        disp(4'b0100, 1'b1, 5'd8);
        bus.i_queue_full = 4'b0100;
        expect_out("qfull", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        expect_out("qfull_nopop", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 1'b0, 6'd0, 1'b0);
        step();

        // Fresh reset, then exhaust all 64 tags
        rst = 1'b1;
        clr();
        expect_out("reset2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            disp(4'b0010, 1'b1, 5'(1 + (i % 31)));
            expect_out("exhaust", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 6'(i), 6'd0, 1'b0, 6'd0, 1'b0);
            step();
        end
        disp(4'b0010, 1'b1, 5'd5);
        expect_out("exhaust_stall", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0010, 1'b1, 5'd0);
        expect_out("x0_write", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd17;
        expect_out("cdb_push", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        expect_out("recycle17", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();

        // Taken branch: wait, flush pulse, resume; CDB branch in IDLE is ignored
        disp(4'b0001, 1'b0, 5'd0);
        bus.i_is_branch = 1'b1;
        expect_out("br_disp", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b0, 5'd0);
        expect_out("br_wait", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        bus.cdb_branch = 1'b1; bus.cdb_branch_taken = 1'b1;
        expect_out("br_resolve", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b0, 5'd0);
        expect_out("flush", 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b0, 5'd0);
        bus.cdb_branch = 1'b1; bus.cdb_branch_taken = 1'b1;
        expect_out("resume", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        expect_out("no_reflush", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();

        // Not-taken branch returns to IDLE without a flush
        disp(4'b0001, 1'b0, 5'd0);
        bus.i_is_branch = 1'b1;
        expect_out("nt_disp", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        bus.cdb_branch = 1'b1; bus.cdb_branch_taken = 1'b0;
        expect_out("nt_resolve", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b0, 5'd0);
        expect_out("nt_resume", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd17, 6'd0, 1'b0, 6'd0, 1'b0);
        step();

        // x9 holds tag 39; redispatch x9 while CDB retires 39: new tag must win
        disp(4'b0001, 1'b1, 5'd9);
        bus.i_rs1_addr = 5'd9;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 6'd39;
        expect_out("collide", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd17, 6'd39, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        bus.i_rs1_addr = 5'd9;
        expect_out("collide_new", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd39, 6'd17, 1'b1, 6'd0, 1'b0);
        step();

        // Reset while waiting on a branch
        disp(4'b0001, 1'b0, 5'd0);
        bus.i_is_branch = 1'b1;
        expect_out("br2_disp", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd39, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        disp(4'b0001, 1'b0, 5'd0);
        bus.i_rs1_addr = 5'd9;
        expect_out("br2_wait", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd39, 6'd17, 1'b1, 6'd0, 1'b0);
        step();
        rst = 1'b1;
        clr();
        bus.i_rs1_addr = 5'd9;
        expect_out("rst_in_wait", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        rst = 1'b0;
        disp(4'b0001, 1'b1, 5'd3);
        expect_out("post_rst", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        step();
        clr();
        bus.i_rs1_addr = 5'd3;
        expect_out("post_rst_pop", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b1, 6'd0, 1'b0);
        step();

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            step();
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
